// File: rtl/aes_block_ctrl.sv
// Drives the AES core's 32-bit register port so that upstream logic sees a 128-bit block stream.
// Optional bounded status polling: define AES_CTRL_TIMEOUT_EN.
module aes_block_ctrl #(
  parameter bit          KEYLEN_256   = 1'b0,
  parameter int unsigned POLL_TIMEOUT = 1024
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         key_load_i,
  input  logic [255:0] key_i,
  input  logic         enc_dec_i,
  output logic         key_ready_o,
  input  logic         blk_valid_i,
  output logic         blk_ready_o,
  input  logic [127:0] blk_data_i,
  output logic         res_valid_o,
  input  logic         res_ready_i,
  output logic [127:0] res_data_o,
  output logic         busy_o,
  output logic         err_o,
  output logic         aes_cs_o,
  output logic         aes_we_o,
  output logic [7:0]   aes_address_o,
  output logic [31:0]  aes_write_data_o,
  input  logic [31:0]  aes_read_data_i
);

  localparam logic [7:0] ADDR_CTRL   = 8'h08;
  localparam logic [7:0] ADDR_STATUS = 8'h09;
  localparam logic [7:0] ADDR_CONFIG = 8'h0A;
  localparam logic [7:0] ADDR_KEY    = 8'h10;
  localparam logic [7:0] ADDR_BLOCK  = 8'h20;
  localparam logic [7:0] ADDR_RESULT = 8'h30;
  localparam logic [2:0] KEY_LAST    = KEYLEN_256 ? 3'd7 : 3'd3;

  typedef enum logic [3:0] {
    IDLE, KEY_WR, CFG_WR, INIT_WR, KEY_GAP, KEY_POLL,
    BLK_WR, NEXT_WR, BLK_GAP, BLK_POLL, RES_RD, OUT
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic [7:0][31:0] key_q;
  logic             enc_q;
  logic [3:0][31:0] blk_q, res_q;
  logic             key_ready_q;
  logic             key_acc, blk_acc, poll_ok, poll_to, res_cap, poll_expired;

`ifdef AES_CTRL_TIMEOUT_EN
  localparam int PCW = $clog2(POLL_TIMEOUT + 1);
  logic [PCW-1:0] poll_cnt_q;
  logic           err_q;

  // Counter restarts on every state change, so each POLL state starts from zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      poll_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (state_d != state_q)
        poll_cnt_q <= '0;
      else if (phase_q && (state_q == KEY_POLL || state_q == BLK_POLL))
        poll_cnt_q <= poll_cnt_q + 1'b1;
      if (poll_to) err_q <= 1'b1;
    end
  end

  assign poll_expired = (poll_cnt_q == PCW'(POLL_TIMEOUT - 1));
  assign err_o        = err_q;
`else
  assign poll_expired = 1'b0;
  assign err_o        = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    phase_d          = phase_q;
    aes_cs_o         = 1'b0;
    aes_we_o         = 1'b0;
    aes_address_o    = 8'h00;
    aes_write_data_o = 32'h0;
    blk_ready_o      = 1'b0;
    key_acc          = 1'b0;
    blk_acc          = 1'b0;
    poll_ok          = 1'b0;
    poll_to          = 1'b0;
    res_cap          = 1'b0;
    case (state_q)
      IDLE: begin
        blk_ready_o = key_ready_q & ~key_load_i;
        if (key_load_i) begin
          key_acc = 1'b1;
          cnt_d   = '0;
          state_d = KEY_WR;
        end else if (blk_valid_i && key_ready_q) begin
          blk_acc = 1'b1;
          cnt_d   = '0;
          state_d = BLK_WR;
        end
      end
      KEY_WR: begin
        aes_cs_o         = 1'b1;
        aes_we_o         = 1'b1;
        aes_address_o    = ADDR_KEY + {5'b0, cnt_q};
        aes_write_data_o = key_q[3'd7 - cnt_q];
        cnt_d            = cnt_q + 3'd1;
        if (cnt_q == KEY_LAST) state_d = CFG_WR;
      end
      CFG_WR: begin
        aes_cs_o         = 1'b1;
        aes_we_o         = 1'b1;
        aes_address_o    = ADDR_CONFIG;
        aes_write_data_o = {30'b0, KEYLEN_256, enc_q};
        state_d          = INIT_WR;
      end
      INIT_WR: begin
        aes_cs_o         = 1'b1;
        aes_we_o         = 1'b1;
        aes_address_o    = ADDR_CTRL;
        aes_write_data_o = 32'h1;
        state_d          = KEY_GAP;
      end
      KEY_GAP: begin
        phase_d = 1'b0;
        state_d = KEY_POLL;
      end
      // Poll: issue cycle, then sample the read data returned one cycle later.
      KEY_POLL: begin
        if (!phase_q) begin
          aes_cs_o      = 1'b1;
          aes_address_o = ADDR_STATUS;
          phase_d       = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (aes_read_data_i[0]) begin
            poll_ok = 1'b1;
            state_d = IDLE;
          end else if (poll_expired) begin
            poll_to = 1'b1;
            state_d = IDLE;
          end
        end
      end
      BLK_WR: begin
        aes_cs_o         = 1'b1;
        aes_we_o         = 1'b1;
        aes_address_o    = ADDR_BLOCK + {5'b0, cnt_q};
        aes_write_data_o = blk_q[2'd3 - cnt_q[1:0]];
        cnt_d            = cnt_q + 3'd1;
        if (cnt_q == 3'd3) state_d = NEXT_WR;
      end
      NEXT_WR: begin
        aes_cs_o         = 1'b1;
        aes_we_o         = 1'b1;
        aes_address_o    = ADDR_CTRL;
        aes_write_data_o = 32'h2;
        state_d          = BLK_GAP;
      end
      BLK_GAP: begin
        phase_d = 1'b0;
        state_d = BLK_POLL;
      end
      BLK_POLL: begin
        if (!phase_q) begin
          aes_cs_o      = 1'b1;
          aes_address_o = ADDR_STATUS;
          phase_d       = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (aes_read_data_i[1]) begin
            cnt_d   = '0;
            state_d = RES_RD;
          end else if (poll_expired) begin
            poll_to = 1'b1;
            state_d = IDLE;
          end
        end
      end
      // Reads issue at cnt 0..3; each word lands one cycle later, so cnt 4 is capture-only.
      RES_RD: begin
        aes_cs_o      = ~cnt_q[2];
        aes_address_o = ADDR_RESULT + {5'b0, cnt_q};
        res_cap       = (cnt_q != 3'd0);
        cnt_d         = cnt_q + 3'd1;
        if (cnt_q == 3'd4) state_d = OUT;
      end
      OUT: begin
        if (res_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      key_q       <= '0;
      enc_q       <= 1'b0;
      blk_q       <= '0;
      res_q       <= '0;
      key_ready_q <= 1'b0;
    end else begin
      if (key_acc) begin
        key_q       <= key_i;
        enc_q       <= enc_dec_i;
        key_ready_q <= 1'b0;
      end
      if (poll_ok) key_ready_q <= 1'b1;
      if (poll_to) key_ready_q <= 1'b0;
      if (blk_acc) blk_q <= blk_data_i;
      if (res_cap) res_q[2'(3'd4 - cnt_q)] <= aes_read_data_i;
    end
  end

  assign key_ready_o = key_ready_q;
  assign res_valid_o = (state_q == OUT);
  assign res_data_o  = res_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_aes_block_ctrl.sv
// Bench for aes_block_ctrl: behavioural AES register-port model, vector table and random blocks.
module tb_aes_block_ctrl;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_load = 1'b0;
  logic [255:0] key_in = '0;
  logic enc = 1'b0;
  logic key_ready;
  logic blk_valid = 1'b0;
  logic blk_ready;
  logic [127:0] blk_data = '0;
  logic res_valid;
  logic res_ready = 1'b0;
  logic [127:0] res_data;
  logic busy, err, aes_cs, aes_we;
  logic [7:0] aes_addr;
  logic [31:0] aes_wdata;
  logic [31:0] aes_rdata = '0;

  always #5 clk = ~clk;

  aes_block_ctrl #(.KEYLEN_256(1'b0), .POLL_TIMEOUT(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .key_load_i(key_load), .key_i(key_in), .enc_dec_i(enc),
    .key_ready_o(key_ready), .blk_valid_i(blk_valid), .blk_ready_o(blk_ready),
    .blk_data_i(blk_data), .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_data_o(res_data), .busy_o(busy), .err_o(err), .aes_cs_o(aes_cs), .aes_we_o(aes_we),
    .aes_address_o(aes_addr), .aes_write_data_o(aes_wdata), .aes_read_data_i(aes_rdata)
  );

  typedef struct packed { logic [7:0] a; logic [31:0] d; } wr_t;
  typedef struct {
    logic [127:0] blk; bit mode; int lat; int hold; logic [127:0] want; int want_lat;
  } vec_t;

  // Stand-in cipher: the known FIPS-197 vector, otherwise key XOR plaintext.
  function automatic logic [127:0] fake_aes(input logic [127:0] k, input logic [127:0] p);
    return (k == FIPS_KEY && p == FIPS_PT) ? FIPS_CT : (k ^ p);
  endfunction

  logic [31:0] cregs [0:255];
  int  klat = 1, blat = 1, key_lat = 1, blk_lat = 1;
  bit  res_mode = 1'b1;
  int  n_stat_rd = 0, n_access = 0, cyc = 0;
  wr_t wq[$];

  function automatic logic [31:0] model_word(input int i);
    logic [127:0] r;
    r = fake_aes({cregs[16], cregs[17], cregs[18], cregs[19]},
                 {cregs[32], cregs[33], cregs[34], cregs[35]});
    return r[127-32*i -: 32];
  endfunction

  // Core model: status latencies counted in reads, read data valid the cycle after the strobe.
  always @(posedge clk) begin
    cyc++;
    if (aes_cs) begin
      n_access++;
      if (aes_we) begin
        wq.push_back({aes_addr, aes_wdata});
        cregs[aes_addr] = aes_wdata;
        if (aes_addr == 8'h08 && aes_wdata[0]) klat = key_lat;
        if (aes_addr == 8'h08 && aes_wdata[1]) blat = blk_lat;
      end else if (aes_addr == 8'h09) begin
        n_stat_rd++;
        aes_rdata <= {30'b0, (blat <= 1), (klat <= 1)};
        if (klat > 1) klat--;
        if (blat > 1) blat--;
      end else if (aes_addr[7:2] == 6'b001100) begin
        aes_rdata <= res_mode ? model_word(int'(aes_addr[1:0])) : 32'hC0DEC0DE + {24'b0, aes_addr};
      end else begin
        aes_rdata <= 32'hDEADBEEF;
      end
    end
  end

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  task automatic chk_wr(input string nm, input int idx, input logic [7:0] a, input logic [31:0] d);
    wr_t w;
    w = (idx < wq.size()) ? wq[idx] : '1;
    chk(nm, w, {a, d});
  endtask

  task automatic wait_blk_ready();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (blk_ready) begin ok = 1'b1; break; end
    end
    chk("blk_ready_seen", ok, 1);
  endtask

  task automatic load_key(input logic [127:0] k, input logic e, input int polls, input int want_lat);
    int t0, lat, base, st0;
    key_lat = polls;
    @(posedge clk); #1;
    base = wq.size(); st0 = n_stat_rd;
    key_in = {k, 128'h0}; enc = e; key_load = 1'b1; t0 = cyc;
    @(posedge clk); #1;
    key_load = 1'b0;
    lat = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (key_ready) begin lat = cyc - t0; break; end
    end
    chk("key_latency", lat, want_lat);
    chk("key_polls", n_stat_rd - st0, polls);
    for (int i = 0; i < 4; i++) chk_wr("key_word", base + i, 8'(8'h10 + i), k[127-32*i -: 32]);
    chk_wr("key_cfg", base + 4, 8'h0A, {31'b0, e});
    chk_wr("key_init", base + 5, 8'h08, 32'h1);
  endtask

  task automatic do_block(input logic [127:0] blk, input logic [127:0] want, input int want_lat,
                          input int hold);
    int t0, lat, base, n0;
    wait_blk_ready();
    @(posedge clk); #1;
    base = wq.size(); blk_valid = 1'b1; blk_data = blk; t0 = cyc;
    @(posedge clk); #1;
    blk_valid = 1'b0;
    lat = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (res_valid) begin lat = cyc - t0; break; end
    end
    chk("res_latency", lat, want_lat);
    chk("res_data", res_data, want);
    for (int i = 0; i < 4; i++) chk_wr("blk_word", base + i, 8'(8'h20 + i), blk[127-32*i -: 32]);
    chk_wr("blk_next", base + 4, 8'h08, 32'h2);
    if (hold > 0) begin
      n0 = n_access; blk_valid = 1'b1; blk_data = ~blk;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_valid", res_valid, 1);
        chk("hold_data", res_data, want);
        chk("hold_blk_ready", blk_ready, 0);
      end
      chk("hold_no_core_access", n_access - n0, 0);
      blk_valid = 1'b0;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    chk("post_res_idle", {busy, res_valid}, 2'b00);
    chk("res_data_held", res_data, want);
  endtask

  initial begin
    vec_t tbl [4];
    int hs[$];
    int t0, lat, base, n0, st0, bl, hd;
    bit ok;
    logic [127:0] rb;

    tbl[0] = '{FIPS_PT, 1'b1, 1, 0, FIPS_CT, 14};
    tbl[1] = '{FIPS_PT, 1'b0, 1, 0,
               {32'hC0DEC10E, 32'hC0DEC10F, 32'hC0DEC110, 32'hC0DEC111}, 14};
    tbl[2] = '{128'h0, 1'b1, 3, 0, FIPS_KEY, 18};
    tbl[3] = '{128'hffffffff_ffffffff_ffffffff_ffffffff, 1'b1, 2, 10,
               128'hfffefdfc_fbfaf9f8_f7f6f5f4_f3f2f1f0, 16};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctl", {key_ready, blk_ready, res_valid, busy, err, aes_cs, aes_we, aes_addr, aes_wdata}, 0);
    chk("reset_res_data", res_data, 0);
    rst_n = 1'b1;
    blk_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_blk_ready_without_key", {blk_ready, busy}, 2'b00);
    blk_valid = 1'b0;

    load_key(FIPS_KEY, 1'b1, 2, 12);

    for (int v = 0; v < 4; v++) begin
      res_mode = tbl[v].mode;
      blk_lat  = tbl[v].lat;
      do_block(tbl[v].blk, tbl[v].want, tbl[v].want_lat, tbl[v].hold);
    end
    res_mode = 1'b1;
    blk_lat  = 1;

    // Back-to-back blocks with res_ready held high.
    @(posedge clk); #1;
    res_ready = 1'b1; blk_valid = 1'b1; blk_data = FIPS_PT;
    for (int i = 0; i < 100 && hs.size() < 3; i++) begin
      @(negedge clk);
      if (blk_ready) hs.push_back(cyc);
    end
    @(posedge clk); #1;
    blk_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    res_ready = 1'b0;
    chk("throughput_gap1", (hs.size() >= 3) ? hs[1] - hs[0] : -1, 15);
    chk("throughput_gap2", (hs.size() >= 3) ? hs[2] - hs[1] : -1, 15);
    chk("throughput_data", res_data, FIPS_CT);

    // Key load and block offered together: key wins.
    @(posedge clk); #1;
    base = wq.size(); key_lat = 1;
    key_in = {FIPS_KEY, 128'h0}; enc = 1'b1; key_load = 1'b1;
    blk_valid = 1'b1; blk_data = 128'h0; t0 = cyc;
    @(negedge clk);
    chk("prio_blk_ready_low", blk_ready, 0);
    @(posedge clk); #1;
    key_load = 1'b0;
    lat = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (blk_ready) begin lat = cyc - t0; break; end
    end
    chk("prio_accept_cycle", lat, 10);
    chk("prio_key_ready", key_ready, 1);
    chk("prio_writes_before_accept", wq.size() - base, 6);
    chk_wr("prio_first_write", base, 8'h10, 32'h00010203);
    @(posedge clk); #1;
    blk_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (res_valid) begin ok = 1'b1; break; end
    end
    chk("prio_res_valid", ok, 1);
    chk("prio_res_data", res_data, FIPS_KEY);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;

    for (int r = 0; r < 16; r++) begin
      rb = {$urandom, $urandom, $urandom, $urandom};
      bl = int'($urandom_range(1, 4));
      hd = int'($urandom_range(0, 2));
      blk_lat = bl;
      do_block(rb, fake_aes(FIPS_KEY, rb), 14 + 2 * (bl - 1), hd);
    end

    // Asynchronous reset while polling for block completion.
    blk_lat = 1000;
    wait_blk_ready();
    @(posedge clk); #1;
    blk_valid = 1'b1; blk_data = FIPS_PT; t0 = cyc;
    @(posedge clk); #1;
    blk_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cyc == t0 + 7) break;
    end
    chk("poll_issue", {aes_cs, aes_we, aes_addr}, {1'b1, 1'b0, 8'h09});
    rst_n = 1'b0;
    #1;
    chk("async_reset_ctl", {key_ready, blk_ready, res_valid, busy, err, aes_cs, aes_we, aes_addr, aes_wdata}, 0);
    chk("async_reset_res_data", res_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n0 = n_access;
    repeat (10) @(negedge clk);
    chk("no_access_after_reset", n_access - n0, 0);
    chk("idle_after_reset", {key_ready, blk_ready, busy}, 3'b000);
    blk_lat = 1;

    load_key(FIPS_KEY, 1'b1, 1, 10);
    for (int r = 0; r < 3; r++) begin
      rb = {$urandom, $urandom, $urandom, $urandom};
      do_block(rb, fake_aes(FIPS_KEY, rb), 14, 0);
    end

`ifdef AES_CTRL_TIMEOUT_EN
    blk_lat = 1000;
    wait_blk_ready();
    @(posedge clk); #1;
    st0 = n_stat_rd; blk_valid = 1'b1; blk_data = FIPS_PT;
    @(posedge clk); #1;
    blk_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (err) break;
    end
    chk("timeout_err", err, 1);
    chk("timeout_polls", n_stat_rd - st0, 8);
    @(negedge clk);
    chk("timeout_idle", {busy, key_ready, res_valid, err}, 4'b0001);
    blk_lat = 1;
`else
    chk("err_tied_low", err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/aes_block_ctrl.md
# aes_block_ctrl

Sequencer that owns the 32-bit register port of the AES core and turns it into a 128-bit streaming block interface. It loads the key and configuration on request, then for each accepted block writes the four plaintext words, triggers `next`, polls status and reads back the four result words. It sits between the RAM/RNG sequencing FSM (block producer/consumer) and the AES core, replacing hand-coded AES register accesses in upstream FSMs.

## Interface
- `KEYLEN_256`, 0, 1 selects a 256-bit key (8 key words); 0 selects 128-bit (4 words, `key_i[255:128]`).
- `POLL_TIMEOUT`, 1024, maximum status polls before error; used only with `AES_CTRL_TIMEOUT_EN`.

Ports:
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `key_load_i`  in  1  pulse: load `key_i` and `enc_dec_i` into the core; sampled only in IDLE.
- `key_i`  in  256  key; word k = `key_i[255-32k -: 32]`.
- `enc_dec_i`  in  1  1 = encrypt, 0 = decrypt.
- `key_ready_o`  out  1  key expansion complete; cleared by a new key load.
- `blk_valid_i` / `blk_ready_o`  in / out  1  input block handshake.
- `blk_data_i`  in  128  block; word w = `blk_data_i[127-32w -: 32]`.
- `res_valid_o` / `res_ready_i`  out / in  1  result handshake.
- `res_data_o`  out  128  result, same word order.
- `busy_o`  out  1  high in every state except IDLE.
- `err_o`  out  1  sticky poll-timeout flag.
- `aes_cs_o`, `aes_we_o`  out  1  core register strobe and write enable.
- `aes_address_o`  out  8  core register address.
- `aes_write_data_o`  out  32  core write data.
- `aes_read_data_i`  in  32  core read data; valid the cycle after a read strobe.

## Operation
- Core map: CTRL 0x08 (bit0 init, bit1 next), STATUS 0x09 (bit0 ready, bit1 valid), CONFIG 0x0A (bit0 enc_dec, bit1 keylen), KEY 0x10–0x17, BLOCK 0x20–0x23, RESULT 0x30–0x33.
- States: IDLE, KEY_WR, CFG_WR, INIT_WR, KEY_GAP, KEY_POLL, BLK_WR, NEXT_WR, BLK_GAP, BLK_POLL, RES_RD, OUT.
- IDLE: `key_load_i` has priority over `blk_valid_i`. `blk_ready_o` = 1 only in IDLE with `key_ready_o` = 1 and `key_load_i` = 0.
- KEY_WR: 4 or 8 consecutive writes to 0x10 and up. CFG_WR writes `{30'b0, KEYLEN_256, enc_dec}`. INIT_WR writes 0x1 to CTRL. KEY_GAP is one idle cycle (cs = 0). KEY_POLL reads STATUS and repeats until bit0 = 1; it then sets `key_ready_o` and returns to IDLE.
- Block path: the handshake captures `blk_data_i`. BLK_WR performs 4 writes to 0x20–0x23. NEXT_WR writes 0x2 to CTRL. BLK_GAP is one idle cycle. BLK_POLL repeats until status bit1 = 1. RES_RD issues reads to 0x30–0x33 on consecutive cycles, and each word is captured one cycle after its address. OUT holds `res_valid_o` until `res_ready_i`, then returns to IDLE.
- Poll iteration takes 2 cycles: an issue cycle (cs = 1, we = 0, addr 0x09), then a sample cycle (cs = 0).
- `res_data_o` stays stable while `res_valid_o` = 1, and it holds its last value after the handshake.
- Outside active accesses, `aes_cs_o` = 0 and `aes_we_o` = 0. Address and write data are don't-care but must be driven.
- `key_load_i` outside IDLE is ignored (not queued).

## Timing
- Reset values: all outputs 0, state IDLE, `key_ready_o` = 0, `err_o` = 0. Reset asserted mid-sequence aborts immediately. The core is not touched until the next key load.
- Key load (128-bit), with `key_load_i` seen in IDLE at cycle T:
  - key writes T+1..T+4, CONFIG T+5, INIT T+6, gap T+7, first poll issue T+8;
  - with immediate ready, `key_ready_o` rises at T+10.
  - For 256-bit, add 4 cycles.
- Block, with handshake at cycle T:
  - block writes T+1..T+4, NEXT T+5, gap T+6, poll T+7/T+8;
  - RES_RD issues T+9..T+12, last capture T+13;
  - `res_valid_o` = 1 from T+14. Minimum throughput is 1 block per 15 cycles with `res_ready_i` held high.
- Each extra poll adds 2 cycles.

## Configuration
- `AES_CTRL_TIMEOUT_EN` defined: a poll counter is cleared on entry to each POLL state. When it reaches `POLL_TIMEOUT` without the awaited bit:
  - `err_o` is set (sticky until reset);
  - the FSM returns to IDLE and clears `key_ready_o`;
  - no result is presented.
- `AES_CTRL_TIMEOUT_EN` undefined: polling is unbounded, no counter is synthesized, and `err_o` is tied 0.

## Test plan
- Reset, then 128-bit key load with key 000102030405060708090a0b0c0d0e0f, enc = 1, and a core model with 2-poll latency: writes appear at 0x10–0x13, 0x0A = 0x1, 0x08 = 0x1; `key_ready_o` rises after exactly 2 poll reads.
- Block 00112233445566778899aabbccddeeff → words 0x00112233..0xccddeeff written to 0x20–0x23 in order; `res_data_o` = 69c4e0d86a7b0430d8cdb78070b4c55a (real core or model).
- Model returning 0xC0DEC0DE + addr at 0x30–0x33 with immediate valid: `res_valid_o` is exactly 14 cycles after acceptance, and `res_data_o` = {C0DEC10E, C0DEC10F, C0DEC110, C0DEC111}.
- `res_ready_i` low for 10 cycles: `res_valid_o` and data hold, `blk_ready_o` stays 0, and no core access occurs.
- `key_load_i` and `blk_valid_i` high together in IDLE: the key load is taken and the block is accepted only after `key_ready_o`. `rst_ni` pulsed in BLK_POLL: all outputs are 0 the same cycle.
- With `AES_CTRL_TIMEOUT_EN` and `POLL_TIMEOUT` = 8, status never valid: `err_o` = 1 after 8 polls, then IDLE with `key_ready_o` = 0.
